// File: rtl/mem_pkg.sv
// Shared defaults and response-register types for the two-port memory arbiter.
package mem_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam int unsigned DEF_MEM_BYTES = 1024;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        D    = 2'd2
    } owner_t;

    // wr marks a data-port write so the response returns zero data.
    typedef struct packed {
        owner_t owner;
        logic   err;
        logic   wr;
    } resp_t;

endpackage

// File: rtl/mem_range_check.sv
// Combinational window/alignment check of a byte address against the shared memory.
module mem_range_check
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic [31:0] addr,
    output logic        ok
);

    // 33-bit arithmetic so a window ending at 2^32 cannot wrap.
    localparam logic [32:0] FIRST = {1'b0, BASE_ADDR};
    localparam logic [32:0] LAST  = {1'b0, BASE_ADDR} + 33'(MEM_BYTES) - 33'd4;

    logic [32:0] addr_ext;

    assign addr_ext = {1'b0, addr};
    assign ok = (addr_ext >= FIRST) && (addr_ext <= LAST) && (addr[1:0] == 2'b00);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data port arbiter onto one single-cycle memory; define MEM_ARB_RR_EN
// for round-robin conflict resolution, otherwise the data port has fixed priority.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    logic  if_ok;
    logic  d_ok;
    logic  d_wins;
    resp_t resp_q;
    resp_t resp_d;

    mem_range_check #(.BASE_ADDR(BASE_ADDR), .MEM_BYTES(MEM_BYTES)) u_if_range (
        .addr (if_addr),
        .ok   (if_ok)
    );

    mem_range_check #(.BASE_ADDR(BASE_ADDR), .MEM_BYTES(MEM_BYTES)) u_d_range (
        .addr (d_addr),
        .ok   (d_ok)
    );

`ifdef MEM_ARB_RR_EN
    // Set after a fetch grant so the data port wins the next conflict.
    logic prefer_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_d <= 1'b0;
        end else if (if_gnt) begin
            prefer_d <= 1'b1;
        end else if (d_gnt) begin
            prefer_d <= 1'b0;
        end
    end

    assign d_wins = prefer_d;
`else
    assign d_wins = 1'b1;
`endif

    // Grants are suppressed during reset so nothing can be launched then.
    always_comb begin
        if_gnt = !rst && if_req && (!d_req || !d_wins);
        d_gnt  = !rst && d_req && (!if_req || d_wins);
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (if_gnt && if_ok) begin
            mem_en   = 1'b1;
            mem_be   = 4'hF;
            mem_addr = if_addr - BASE_ADDR;
        end else if (d_gnt && d_ok) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr - BASE_ADDR;
            mem_wdata = d_wdata;
        end
    end

    always_comb begin
        resp_d = '{owner: NONE, err: 1'b0, wr: 1'b0};
        if (if_gnt) begin
            resp_d = '{owner: IF, err: !if_ok, wr: 1'b0};
        end else if (d_gnt) begin
            resp_d = '{owner: D, err: !d_ok, wr: d_we};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q <= '{owner: NONE, err: 1'b0, wr: 1'b0};
        end else begin
            resp_q <= resp_d;
        end
    end

    always_comb begin
        if_rvalid = 1'b0;
        if_err    = 1'b0;
        if_rdata  = 32'h0;
        d_rvalid  = 1'b0;
        d_err     = 1'b0;
        d_rdata   = 32'h0;
        if (!rst) begin
            if (resp_q.owner == IF) begin
                if_rvalid = 1'b1;
                if_err    = resp_q.err;
                if_rdata  = resp_q.err ? 32'h0 : mem_rdata;
            end
            if (resp_q.owner == D) begin
                d_rvalid = 1'b1;
                d_err    = resp_q.err;
                d_rdata  = (resp_q.err || resp_q.wr) ? 32'h0 : mem_rdata;
            end
        end
    end

endmodule
